// File: rtl/barcode_reader.sv
// Station-ID barcode decoder: self-calibrates the cell timing from the start
// cell, then samples 8 pulse-width-coded data bits MSB first.
module barcode_reader #(
  parameter int unsigned CNT_W = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_FALL = 3'd2,
    SAMPLE    = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic bc_s1, bc_s2, bc_prev;
  logic fall;

  logic [CNT_W-1:0] dur, dur_nxt;
  logic [CNT_W-1:0] d_reg, d_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] tmo, tmo_nxt;
  logic [2:0]       bitcnt, bitcnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       id_nxt;
  logic             vld_nxt;

  // Two-flop synchronizer plus one edge-detect stage; idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      bc_s1   <= 1'b1;
      bc_s2   <= 1'b1;
      bc_prev <= 1'b1;
    end else begin
      bc_s1   <= BC;
      bc_s2   <= bc_s1;
      bc_prev <= bc_s2;
    end
  end

  assign fall = bc_prev & ~bc_s2;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dur    <= '0;
      d_reg  <= '0;
      cnt    <= '0;
      tmo    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      ID     <= '0;
      ID_vld <= 1'b0;
      busy   <= 1'b0;
    end else begin
      dur    <= dur_nxt;
      d_reg  <= d_nxt;
      cnt    <= cnt_nxt;
      tmo    <= tmo_nxt;
      bitcnt <= bitcnt_nxt;
      shreg  <= shreg_nxt;
      ID     <= id_nxt;
      ID_vld <= vld_nxt;
      busy   <= (state_nxt != IDLE);
    end
  end

  // Next-state, counter and output-register logic
  always_comb begin
    state_nxt  = state;
    dur_nxt    = dur;
    d_nxt      = d_reg;
    cnt_nxt    = cnt;
    tmo_nxt    = tmo;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    id_nxt     = ID;
    vld_nxt    = ID_vld;

    // Acknowledge clears the flag; a same-cycle valid frame overrides below
    if (clr_ID_vld) vld_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt  = START;
          dur_nxt    = '0;
          bitcnt_nxt = '0;
        end
      end

      START: begin
        if (!bc_s2) begin
          if (dur != CNT_MAX) dur_nxt = dur + CNT_W'(1);
        end else if (dur == '0) begin
          // Zero-length start pulse is a glitch, not a frame
          state_nxt = IDLE;
        end else begin
          d_nxt     = dur;
          tmo_nxt   = '0;
          state_nxt = WAIT_FALL;
        end
      end

      WAIT_FALL: begin
        if (fall) begin
          state_nxt = SAMPLE;
          cnt_nxt   = '0;
        end else if ({2'b00, tmo} >= {d_reg, 2'b00}) begin
          state_nxt = IDLE;
        end else if (tmo != CNT_MAX) begin
          tmo_nxt = tmo + CNT_W'(1);
        end
      end

      SAMPLE: begin
        // Sample half a start-pulse after the cell's falling edge
        if (cnt == (d_reg >> 1)) begin
          shreg_nxt  = {shreg[6:0], bc_s2};
          bitcnt_nxt = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT_FALL;
            tmo_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        // Station IDs never use the top two bits; anything else is corrupt
        if (shreg[7:6] == 2'b00) begin
          id_nxt  = shreg;
          vld_nxt = 1'b1;
        end
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
